csi2_pkt_framer: RTL and testbench
==================================

// Module: csi2_pkt_framer
// PURPOSE
//  Byte-clock stage between the 4-lane MIPI D-PHY RX and the CSI-2 packet decoder.
//  - Detects the SoT sync word, parses the packet header and counts the payload bytes plus CRC.
//  - Outputs the lane bytes delayed by one cycle, with a `ready_out` window covering exactly one packet.
//  - Replaces the ad-hoc SoT/word-count gating in the top level; `ready_out` drives the decoder's I_READY.
// PARAMETERS
//  SYNC_BYTE  8'hB8     per-lane SoT sync value; all 4 lanes must match in the same cycle
//  MAX_WC     16'd8192  largest word count accepted; larger counts are treated as header errors
//  SHORT_DT   6'h10     data types below this value are short packets (no payload)
// PORTS
//  clk_byte   in   1   byte clock from the D-PHY
//  nrst       in   1   asynchronous active-low reset
//  hs_valid   in   1   PHY ready/HS-active; low aborts any packet in progress
//  data_in    in   32  lane bytes, [7:0]=lane0 .. [31:24]=lane3
//  data_out   out  32  data_in delayed by 1 cycle
//  ready_out  out  1   high for the sync, header and payload cycles of data_out
//  pkt_start  out  1   1-cycle pulse, aligned with the header cycle on data_out
//  pkt_dt     out  6   data type of the last accepted header
//  pkt_wc     out  16  word count of the last accepted header
//  pkt_err    out  1   1-cycle pulse: bad header (oversize WC, or ECC mismatch) or abort
//  pkt_cnt    out  16  completed packets, wraps at 2^16
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE; beat counter 0.
//  Timing: all outputs are registered. data_out and ready_out are both delayed 1 cycle, so they stay aligned.
//  Header lane map: lane0=DI (VC[7:6], DT[5:0]), lane1=WC[7:0], lane2=WC[15:8], lane3=ECC.
//  FSM states:
//   - IDLE: if hs_valid and all lanes==SYNC_BYTE -> HDR, ready_out<=1. Otherwise ready_out<=0.
//   - HDR:
//     - Always ready_out<=1.
//     - Capture dt/wc and pulse pkt_start.
//     - Short DT (<SHORT_DT) -> IDLE; pkt_cnt++.
//     - Long DT -> PAYLOAD with beats=(wc+5)>>2, i.e. ceil((wc+2)/4). Use 17-bit arithmetic, no overflow.
//     - wc==0 on a long packet -> beats=1 (CRC only).
//     - wc>MAX_WC -> IDLE, pkt_err pulse; header stays visible, no payload window.
//   - PAYLOAD:
//     - ready_out<=1; beats decrements each cycle.
//     - When beats==1 -> IDLE, pkt_cnt++.
//     - A sync pattern inside the payload is treated as data; no resync.
//  Abort: hs_valid low in HDR or PAYLOAD -> IDLE, ready_out<=0 next cycle, pkt_err pulse, pkt_cnt unchanged.
//  Back-to-back packets: the sync word arriving on the cycle after the last payload beat is detected in IDLE, with no gap.
//  Reset mid-packet: immediate return to reset values; pkt_dt/pkt_wc cleared.
//  Sync on lanes 0-2 only (lane3 differs): not a SoT; stay in IDLE.
// CONFIGURATION
//  CSI2_FRAMER_ECC_EN defined:
//   - HDR computes the 6-bit CSI-2 header ECC over {WC,DI} and compares it to lane3[5:0].
//   - On mismatch: behave as oversize WC (pkt_err, no payload window, pkt_start suppressed).
//   - Single-bit correction is not performed.
//  Undefined: the ECC byte is ignored; no ECC logic is instantiated.
// STRUCTURE
//  csi2_defs.vh (shared):
//   - SYNC_BYTE default and DT constants (FS=6'h00, FE=6'h01, YUV422_8=6'h1E);
//   - ECC parity-mask table, lane index defines.
//  Sub-module csi2_hdr_ecc: combinational 24b->6b ECC. Instantiated only under CSI2_FRAMER_ECC_EN.
// TESTING
//  1. Short frame start: sync x4, then DI=00 WC=0000 ECC=00.
//     -> ready_out high for 2 cycles, pkt_start 1 pulse, pkt_dt=0, pkt_cnt=1.
//  2. Long packet DI=1E WC=0A00, correct ECC.
//     -> ready_out high 2+641 cycles, deasserts on the following cycle, pkt_wc=0A00, pkt_cnt+1.
//  3. Long packet WC=0001, then immediate next sync.
//     -> 1 payload beat; second packet is framed with no idle cycle.
//  4. hs_valid dropped on payload beat 100 of a WC=0A00 packet.
//     -> ready_out low next cycle, pkt_err pulse, pkt_cnt unchanged, the next sync is accepted.
//  5. WC=0x4000 (>MAX_WC)
//     -> ready_out 2 cycles only, pkt_err pulse. With ECC_EN, a flipped ECC bit gives the same result.
//  6. Lanes B8,B8,B8,00, then header bytes.
//     -> ready_out never asserts; nrst low mid-payload clears all outputs asynchronously.

Source files
------------

// File: rtl/csi2_pkt_framer_pkg.sv
// csi2_pkt_framer_pkg: shared constants, FSM state type and helpers for the
// CSI-2 packet framer and its header ECC sub-module.
package csi2_pkt_framer_pkg;

    // Per-lane SoT sync value, largest accepted word count, first long data type
    localparam logic [7:0]  SYNC_BYTE = 8'hB8;
    localparam logic [15:0] MAX_WC    = 16'd8192;
    localparam logic [5:0]  SHORT_DT  = 6'h10;

    // Byte lane positions of the header fields inside the 32-bit lane word
    localparam int LANE_DI    = 0;
    localparam int LANE_WC_LO = 1;
    localparam int LANE_WC_HI = 2;

    // CSI-2 header ECC parity masks over the 24-bit {WC, DI} word, index = parity bit
    localparam logic [5:0][23:0] ECC_MASK = {
        24'hEFFC00,
        24'hDF03F0,
        24'hB8E38E,
        24'h749A6D,
        24'hF2555B,
        24'hF12CB7
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    // Payload plus 2-byte CRC, rounded up to whole 4-byte beats: ceil((wc+2)/4)
    function automatic logic [14:0] payload_beats(input logic [15:0] wc);
        logic [16:0] sum;
        sum = {1'b0, wc} + 17'd5;
        return sum[16:2];
    endfunction

endpackage

// File: rtl/csi2_hdr_ecc.sv
// csi2_hdr_ecc: combinational 6-bit CSI-2 packet header ECC over {WC, DI}.
// Only instantiated when CSI2_FRAMER_ECC_EN is defined.
module csi2_hdr_ecc
    import csi2_pkt_framer_pkg::*;
(
    input  logic [23:0] hdr,
    output logic [5:0]  ecc
);

    // Each parity bit is the XOR of the header bits selected by its mask
    always_comb begin
        ecc = '0;
        for (int i = 0; i < 6; i++) begin
            ecc[i] = ^(hdr & ECC_MASK[i]);
        end
    end

endmodule

// File: rtl/csi2_pkt_framer.sv
// csi2_pkt_framer: byte-clock framer between the 4-lane D-PHY RX and the
// CSI-2 decoder. Finds the SoT sync word, parses the header, counts payload
// beats and produces a ready_out window aligned with the 1-cycle-delayed lanes.
// Optional header ECC checking is enabled by defining CSI2_FRAMER_ECC_EN.
module csi2_pkt_framer
    import csi2_pkt_framer_pkg::*;
(
    input  logic        clk_byte,
    input  logic        nrst,
    input  logic        hs_valid,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready_out,
    output logic        pkt_start,
    output logic [5:0]  pkt_dt,
    output logic [15:0] pkt_wc,
    output logic        pkt_err,
    output logic [15:0] pkt_cnt
);

    state_t      state;
    state_t      state_next;
    logic [14:0] beat_cnt;
    logic [14:0] beat_next;
    logic        ready_next;
    logic        start_next;
    logic        err_next;
    logic        cnt_inc;
    logic        capture;
    logic        is_sync;
    logic        ecc_bad;
    logic        hdr_bad;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;

    assign hdr_dt  = data_in[LANE_DI*8 +: 6];
    assign hdr_wc  = {data_in[LANE_WC_HI*8 +: 8], data_in[LANE_WC_LO*8 +: 8]};
    assign is_sync = (data_in[7:0]   == SYNC_BYTE) && (data_in[15:8]  == SYNC_BYTE) &&
                     (data_in[23:16] == SYNC_BYTE) && (data_in[31:24] == SYNC_BYTE);

`ifdef CSI2_FRAMER_ECC_EN
    logic [5:0] ecc_calc;

    csi2_hdr_ecc u_hdr_ecc (
        .hdr (data_in[23:0]),
        .ecc (ecc_calc)
    );

    // Lane3 bits [7:6] are reserved and not part of the comparison
    assign ecc_bad = (ecc_calc != data_in[29:24]);
`else
    assign ecc_bad = 1'b0;
`endif

    assign hdr_bad = (hdr_wc > MAX_WC) || ecc_bad;

    // Next-state and next-output decode; an hs_valid drop always wins over normal progress
    always_comb begin
        state_next = state;
        beat_next  = beat_cnt;
        ready_next = 1'b0;
        start_next = 1'b0;
        err_next   = 1'b0;
        cnt_inc    = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hs_valid && is_sync) begin
                    state_next = ST_HDR;
                    ready_next = 1'b1;
                end
            end
            ST_HDR: begin
                state_next = ST_IDLE;
                if (!hs_valid) begin
                    err_next = 1'b1;
                end else begin
                    ready_next = 1'b1;
                    if (hdr_bad) begin
                        err_next = 1'b1;
                    end else begin
                        start_next = 1'b1;
                        capture    = 1'b1;
                        if (hdr_dt < SHORT_DT) begin
                            cnt_inc = 1'b1;
                        end else begin
                            state_next = ST_PAYLOAD;
                            beat_next  = payload_beats(hdr_wc);
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!hs_valid) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end else begin
                    ready_next = 1'b1;
                    beat_next  = beat_cnt - 15'd1;
                    if (beat_cnt == 15'd1) begin
                        state_next = ST_IDLE;
                        cnt_inc    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, beat counter and all registered outputs
    always_ff @(posedge clk_byte or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            data_out  <= '0;
            ready_out <= 1'b0;
            pkt_start <= 1'b0;
            pkt_dt    <= '0;
            pkt_wc    <= '0;
            pkt_err   <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            state     <= state_next;
            beat_cnt  <= beat_next;
            data_out  <= data_in;
            ready_out <= ready_next;
            pkt_start <= start_next;
            pkt_err   <= err_next;
            if (capture) begin
                pkt_dt <= hdr_dt;
                pkt_wc <= hdr_wc;
            end
            if (cnt_inc) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_csi2_pkt_framer.sv
// tb_csi2_pkt_framer: self-checking bench for csi2_pkt_framer. Packets are
// described at packet level (DI, WC, ECC error, abort point) and the expected
// ready window length, pulse counts and header/counter outputs are derived
// from the CSI-2 framing rules. Honours CSI2_FRAMER_ECC_EN when defined.
module tb_csi2_pkt_framer;

    localparam logic [31:0] SYNC_WORD = 32'hB8B8B8B8;
    localparam int          MAX_WC    = 8192;
    localparam int          SHORT_DT  = 16;
`ifdef CSI2_FRAMER_ECC_EN
    localparam bit          ECC_ON    = 1'b1;
`else
    localparam bit          ECC_ON    = 1'b0;
`endif

    logic        clk_byte = 1'b0;
    logic        nrst     = 1'b0;
    logic        hs_valid = 1'b0;
    logic [31:0] data_in  = '0;
    logic [31:0] data_out;
    logic        ready_out;
    logic        pkt_start;
    logic [5:0]  pkt_dt;
    logic [15:0] pkt_wc;
    logic        pkt_err;
    logic [15:0] pkt_cnt;

    int n_err = 0;
    int n_chk = 0;

    int obs_ready;
    int obs_start;
    int obs_err;
    int obs_dbad;

    logic [15:0] exp_cnt = '0;
    logic [5:0]  exp_dt  = '0;
    logic [15:0] exp_wc  = '0;

    csi2_pkt_framer dut (
        .clk_byte  (clk_byte),
        .nrst      (nrst),
        .hs_valid  (hs_valid),
        .data_in   (data_in),
        .data_out  (data_out),
        .ready_out (ready_out),
        .pkt_start (pkt_start),
        .pkt_dt    (pkt_dt),
        .pkt_wc    (pkt_wc),
        .pkt_err   (pkt_err),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk_byte = ~clk_byte;

    // CSI-2 header ECC written directly from the parity equations
    function automatic logic [5:0] ref_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    function automatic logic [31:0] filler();
        logic [31:0] w;
        w = $urandom;
        if (w == SYNC_WORD) w[31:24] = 8'h00;
        return w;
    endfunction

    task automatic clear_obs();
        obs_ready = 0;
        obs_start = 0;
        obs_err   = 0;
        obs_dbad  = 0;
    endtask

    // One byte-clock cycle: drive, let the edge sample, then observe 1 ns later
    task automatic step(input logic [31:0] d, input logic hs);
        data_in  = d;
        hs_valid = hs;
        @(posedge clk_byte);
        #1;
        if (ready_out === 1'b1) obs_ready++;
        if (pkt_start === 1'b1) obs_start++;
        if (pkt_err === 1'b1)   obs_err++;
        if (data_out !== d)     obs_dbad++;
    endtask

    // Expected window/pulses for one packet; updates the model's header and counter view.
    // abort_beat: -1 none, 0 abort on the header, k>0 abort on payload beat k
    task automatic model_packet(input logic [7:0] di, input logic [15:0] wc, input bit flip,
                                input int abort_beat, output int e_ready, output int e_start,
                                output int e_err);
        bit bad;
        int beats;
        bad   = (int'(wc) > MAX_WC) || (ECC_ON && flip);
        beats = (int'(wc) + 2 + 3) / 4;
        if (abort_beat == 0) begin
            e_ready = 1;
            e_start = 0;
            e_err   = 1;
            return;
        end
        e_ready = 2;
        e_start = bad ? 0 : 1;
        e_err   = bad ? 1 : 0;
        if (bad) return;
        exp_dt = di[5:0];
        exp_wc = wc;
        if (int'(di[5:0]) < SHORT_DT) begin
            exp_cnt++;
            return;
        end
        if (abort_beat >= 1 && abort_beat <= beats) begin
            e_ready += abort_beat - 1;
            e_err    = 1;
        end else begin
            e_ready += beats;
            exp_cnt++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] di, input logic [15:0] wc, input bit flip,
                                 input int abort_beat, input bit sync_in_payload);
        logic [5:0]  ecc;
        logic [31:0] hdr;
        int          beats;
        int          b;
        ecc = ref_ecc({wc, di});
        if (flip) begin
            b      = int'($urandom_range(5, 0));
            ecc[b] = ~ecc[b];
        end
        hdr   = {2'b00, ecc, wc, di};
        beats = (int'(wc) + 5) / 4;
        step(SYNC_WORD, 1'b1);
        if (abort_beat == 0) begin
            step(hdr, 1'b0);
            return;
        end
        step(hdr, 1'b1);
        if (int'(di[5:0]) < SHORT_DT || int'(wc) > MAX_WC || (ECC_ON && flip)) return;
        for (int k = 1; k <= beats; k++) begin
            if (k == abort_beat) begin
                step(filler(), 1'b0);
                return;
            end
            step((sync_in_payload && k == 1) ? SYNC_WORD : filler(), 1'b1);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(posedge clk_byte);
        #1;
        n_chk++; if (data_out !== 32'h0) begin n_err++; $display("[TB] FAIL reset_data_out: got %h expected 0", data_out); end
        n_chk++; if (ready_out !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ready: got %b expected 0", ready_out); end
        n_chk++; if (pkt_start !== 1'b0) begin n_err++; $display("[TB] FAIL reset_start: got %b expected 0", pkt_start); end
        n_chk++; if (pkt_err !== 1'b0)   begin n_err++; $display("[TB] FAIL reset_err: got %b expected 0", pkt_err); end
        n_chk++; if (pkt_cnt !== 16'h0)  begin n_err++; $display("[TB] FAIL reset_cnt: got %0d expected 0", pkt_cnt); end
        n_chk++; if (pkt_wc !== 16'h0)   begin n_err++; $display("[TB] FAIL reset_wc: got %h expected 0", pkt_wc); end
        n_chk++; if (pkt_dt !== 6'h0)    begin n_err++; $display("[TB] FAIL reset_dt: got %h expected 0", pkt_dt); end
        @(negedge clk_byte);
        nrst = 1'b1;
        exp_cnt = '0; exp_dt = '0; exp_wc = '0;
    endtask

    task automatic test_short_frame();
        int er, es, ee;
        clear_obs();
        step(filler(), 1'b1);
        model_packet(8'h00, 16'h0000, 1'b0, -1, er, es, ee);
        applyStimulus(8'h00, 16'h0000, 1'b0, -1, 1'b0);
        step(filler(), 1'b1);
        n_chk++; if (obs_ready !== 2) begin n_err++; $display("[TB] FAIL short_ready: got %0d expected 2", obs_ready); end
        n_chk++; if (obs_start !== 1) begin n_err++; $display("[TB] FAIL short_start: got %0d expected 1", obs_start); end
        n_chk++; if (pkt_dt !== 6'h00) begin n_err++; $display("[TB] FAIL short_dt: got %h expected 00", pkt_dt); end
        n_chk++; if (pkt_cnt !== 16'd1) begin n_err++; $display("[TB] FAIL short_cnt: got %0d expected 1", pkt_cnt); end
        n_chk++; if (obs_err !== 0) begin n_err++; $display("[TB] FAIL short_err: got %0d expected 0", obs_err); end
    endtask

    task automatic test_long_packet();
        int er, es, ee;
        clear_obs();
        model_packet(8'h1E, 16'h0A00, 1'b0, -1, er, es, ee);
        applyStimulus(8'h1E, 16'h0A00, 1'b0, -1, 1'b1);
        step(filler(), 1'b1);
        n_chk++; if (obs_ready !== 643) begin n_err++; $display("[TB] FAIL long_ready: got %0d expected 643", obs_ready); end
        n_chk++; if (ready_out !== 1'b0) begin n_err++; $display("[TB] FAIL long_ready_end: got %b expected 0", ready_out); end
        n_chk++; if (pkt_wc !== 16'h0A00) begin n_err++; $display("[TB] FAIL long_wc: got %h expected 0a00", pkt_wc); end
        n_chk++; if (pkt_cnt !== exp_cnt) begin n_err++; $display("[TB] FAIL long_cnt: got %0d expected %0d", pkt_cnt, exp_cnt); end
        n_chk++; if (obs_dbad !== 0) begin n_err++; $display("[TB] FAIL long_data_out: got %0d bad beats expected 0", obs_dbad); end
    endtask

    task automatic test_back_to_back();
        int er, es, ee;
        clear_obs();
        model_packet(8'h2A, 16'h0001, 1'b0, -1, er, es, ee);
        model_packet(8'h01, 16'h0000, 1'b0, -1, er, es, ee);
        applyStimulus(8'h2A, 16'h0001, 1'b0, -1, 1'b0);
        applyStimulus(8'h01, 16'h0000, 1'b0, -1, 1'b0);
        step(filler(), 1'b1);
        n_chk++; if (obs_ready !== 5) begin n_err++; $display("[TB] FAIL b2b_ready: got %0d expected 5", obs_ready); end
        n_chk++; if (obs_start !== 2) begin n_err++; $display("[TB] FAIL b2b_start: got %0d expected 2", obs_start); end
        n_chk++; if (pkt_cnt !== exp_cnt) begin n_err++; $display("[TB] FAIL b2b_cnt: got %0d expected %0d", pkt_cnt, exp_cnt); end
        n_chk++; if (pkt_dt !== 6'h01) begin n_err++; $display("[TB] FAIL b2b_dt: got %h expected 01", pkt_dt); end
    endtask

    task automatic test_abort();
        int er, es, ee;
        logic [15:0] cnt_before;
        cnt_before = exp_cnt;
        clear_obs();
        model_packet(8'h1E, 16'h0A00, 1'b0, 100, er, es, ee);
        applyStimulus(8'h1E, 16'h0A00, 1'b0, 100, 1'b0);
        n_chk++; if (ready_out !== 1'b0) begin n_err++; $display("[TB] FAIL abort_ready_drop: got %b expected 0", ready_out); end
        n_chk++; if (pkt_err !== 1'b1) begin n_err++; $display("[TB] FAIL abort_err_pulse: got %b expected 1", pkt_err); end
        step(filler(), 1'b1);
        n_chk++; if (obs_ready !== 101) begin n_err++; $display("[TB] FAIL abort_ready: got %0d expected 101", obs_ready); end
        n_chk++; if (obs_err !== 1) begin n_err++; $display("[TB] FAIL abort_err: got %0d expected 1", obs_err); end
        n_chk++; if (pkt_cnt !== cnt_before) begin n_err++; $display("[TB] FAIL abort_cnt: got %0d expected %0d", pkt_cnt, cnt_before); end
        clear_obs();
        model_packet(8'h01, 16'h0000, 1'b0, -1, er, es, ee);
        applyStimulus(8'h01, 16'h0000, 1'b0, -1, 1'b0);
        n_chk++; if (obs_start !== 1) begin n_err++; $display("[TB] FAIL abort_resync: got %0d expected 1", obs_start); end
        n_chk++; if (pkt_cnt !== cnt_before + 16'd1) begin n_err++; $display("[TB] FAIL abort_resync_cnt: got %0d expected %0d", pkt_cnt, cnt_before + 16'd1); end
    endtask

    task automatic test_oversize();
        int er, es, ee;
        logic [15:0] cnt_before;
        logic [15:0] wc_before;
        cnt_before = exp_cnt;
        wc_before  = exp_wc;
        clear_obs();
        model_packet(8'h1E, 16'h4000, 1'b0, -1, er, es, ee);
        applyStimulus(8'h1E, 16'h4000, 1'b0, -1, 1'b0);
        step(filler(), 1'b1);
        step(filler(), 1'b1);
        n_chk++; if (obs_ready !== 2) begin n_err++; $display("[TB] FAIL oversize_ready: got %0d expected 2", obs_ready); end
        n_chk++; if (obs_err !== 1) begin n_err++; $display("[TB] FAIL oversize_err: got %0d expected 1", obs_err); end
        n_chk++; if (obs_start !== 0) begin n_err++; $display("[TB] FAIL oversize_start: got %0d expected 0", obs_start); end
        n_chk++; if (pkt_cnt !== cnt_before) begin n_err++; $display("[TB] FAIL oversize_cnt: got %0d expected %0d", pkt_cnt, cnt_before); end
        n_chk++; if (pkt_wc !== wc_before) begin n_err++; $display("[TB] FAIL oversize_wc: got %h expected %h", pkt_wc, wc_before); end
`ifdef CSI2_FRAMER_ECC_EN
        clear_obs();
        model_packet(8'h1E, 16'h0010, 1'b1, -1, er, es, ee);
        applyStimulus(8'h1E, 16'h0010, 1'b1, -1, 1'b0);
        step(filler(), 1'b1);
        n_chk++; if (obs_ready !== 2) begin n_err++; $display("[TB] FAIL ecc_ready: got %0d expected 2", obs_ready); end
        n_chk++; if (obs_err !== 1) begin n_err++; $display("[TB] FAIL ecc_err: got %0d expected 1", obs_err); end
        n_chk++; if (obs_start !== 0) begin n_err++; $display("[TB] FAIL ecc_start: got %0d expected 0", obs_start); end
`endif
    endtask

    task automatic test_partial_sync_and_reset();
        int er, es, ee;
        clear_obs();
        step(32'h00B8B8B8, 1'b1);
        step({2'b00, ref_ecc(24'h00201E), 24'h00201E}, 1'b1);
        repeat (4) step(filler(), 1'b1);
        step(SYNC_WORD, 1'b0);
        step(filler(), 1'b1);
        n_chk++; if (obs_ready !== 0) begin n_err++; $display("[TB] FAIL partial_sync_ready: got %0d expected 0", obs_ready); end
        n_chk++; if (obs_start !== 0) begin n_err++; $display("[TB] FAIL partial_sync_start: got %0d expected 0", obs_start); end
        step(SYNC_WORD, 1'b1);
        step({2'b00, ref_ecc(24'h0A001E), 24'h0A001E}, 1'b1);
        repeat (10) step(filler(), 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        n_chk++; if (ready_out !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_ready: got %b expected 0", ready_out); end
        n_chk++; if (data_out !== 32'h0) begin n_err++; $display("[TB] FAIL midrst_data_out: got %h expected 0", data_out); end
        n_chk++; if (pkt_wc !== 16'h0) begin n_err++; $display("[TB] FAIL midrst_wc: got %h expected 0", pkt_wc); end
        n_chk++; if (pkt_dt !== 6'h0) begin n_err++; $display("[TB] FAIL midrst_dt: got %h expected 0", pkt_dt); end
        n_chk++; if (pkt_cnt !== 16'h0) begin n_err++; $display("[TB] FAIL midrst_cnt: got %0d expected 0", pkt_cnt); end
        @(negedge clk_byte);
        nrst = 1'b1;
        exp_cnt = '0; exp_dt = '0; exp_wc = '0;
        clear_obs();
        model_packet(8'h00, 16'h0007, 1'b0, -1, er, es, ee);
        applyStimulus(8'h00, 16'h0007, 1'b0, -1, 1'b0);
        n_chk++; if (pkt_cnt !== 16'd1) begin n_err++; $display("[TB] FAIL postrst_cnt: got %0d expected 1", pkt_cnt); end
    endtask

    task automatic test_random();
        int          er, es, ee, gap, abort_beat, sel;
        logic [7:0]  di;
        logic [15:0] wc;
        bit          flip, sip;
        for (int n = 0; n < 40; n++) begin
            di  = 8'($urandom);
            sel = int'($urandom_range(9, 0));
            if (sel <= 5)      wc = 16'($urandom_range(64, 0));
            else if (sel == 6) wc = 16'h0000;
            else if (sel == 7) wc = 16'($urandom_range(65535, 8193));
            else if (sel == 8) wc = 16'($urandom_range(3000, 1000));
            else               wc = (n == 9) ? 16'd8192 : 16'd8193;
            flip       = ($urandom_range(4, 0) == 0);
            abort_beat = ($urandom_range(5, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            sip        = ($urandom_range(3, 0) == 0);
            gap        = int'($urandom_range(3, 0));
            clear_obs();
            model_packet(di, wc, flip, abort_beat, er, es, ee);
            applyStimulus(di, wc, flip, abort_beat, sip);
            for (int g = 0; g < gap; g++) begin
                if (g == 0) step(SYNC_WORD, 1'b0);
                else        step(filler(), 1'($urandom));
            end
            n_chk++; if (obs_ready !== er) begin n_err++; $display("[TB] FAIL rnd%0d_ready: got %0d expected %0d (di=%h wc=%h)", n, obs_ready, er, di, wc); end
            n_chk++; if (obs_start !== es) begin n_err++; $display("[TB] FAIL rnd%0d_start: got %0d expected %0d", n, obs_start, es); end
            n_chk++; if (obs_err !== ee)   begin n_err++; $display("[TB] FAIL rnd%0d_err: got %0d expected %0d", n, obs_err, ee); end
            n_chk++; if (pkt_cnt !== exp_cnt) begin n_err++; $display("[TB] FAIL rnd%0d_cnt: got %0d expected %0d", n, pkt_cnt, exp_cnt); end
            n_chk++; if (pkt_dt !== exp_dt) begin n_err++; $display("[TB] FAIL rnd%0d_dt: got %h expected %h", n, pkt_dt, exp_dt); end
            n_chk++; if (pkt_wc !== exp_wc) begin n_err++; $display("[TB] FAIL rnd%0d_wc: got %h expected %h", n, pkt_wc, exp_wc); end
            n_chk++; if (obs_dbad !== 0) begin n_err++; $display("[TB] FAIL rnd%0d_data_out: got %0d bad beats expected 0", n, obs_dbad); end
        end
    endtask

    initial begin
        $display("[TB] csi2_pkt_framer bench, ECC checking %0d", ECC_ON);
        test_reset();
        test_short_frame();
        test_long_packet();
        test_back_to_back();
        test_abort();
        test_oversize();
        test_partial_sync_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
